jy61p_angle_rx: RTL and testbench
=================================

JY61P_ANGLE_RX -- requirements
Module: jy61p_angle_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, PCLK frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division).
REQ-003 SHALL have port PCLK  input  1  clock; all logic rising-edge.
REQ-004 SHALL have port PRESETn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port jy61p_uart_rx  input  1  asynchronous 8N1 serial line from sensor, idle high.
REQ-006 SHALL have port roll  output  16  last accepted roll word, two's complement.
REQ-007 SHALL have port pitch  output  16  last accepted pitch word.
REQ-008 SHALL have port yaw  output  16  last accepted yaw word.
REQ-009 SHALL have port angle_valid  output  1  one-cycle pulse when roll/pitch/yaw update.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on discarded frame (checksum, stop bit, timeout).

Function
REQ-011 SHALL pass jy61p_uart_rx through a 2-flop synchronizer (reset value 1) before any use.
REQ-012 UART RX SHALL detect a start on synchronized 1->0 while idle, resample at CLKS_PER_BIT/2 and abort to idle if high.
REQ-013 UART RX SHALL sample 8 data bits LSB first, each CLKS_PER_BIT after the previous sample, then the stop bit.
REQ-014 Stop bit high SHALL produce a one-cycle byte strobe with the byte; stop bit low SHALL drop the byte and, if a frame is in progress, pulse frame_err and return parser to HUNT.
REQ-015 Parser FSM states SHALL be HUNT, TYPE, DATA, SUM.
REQ-016 HUNT: byte 0x55 -> TYPE, checksum accumulator := 0x55; other bytes ignored.
REQ-017 TYPE: 0x53 -> DATA, accumulator += 0x53, index := 0; 0x55 -> stay TYPE, accumulator := 0x55; other -> HUNT, no frame_err.
REQ-018 DATA: store byte at index 0..7 (RollL, RollH, PitchL, PitchH, YawL, YawH, VL, VH), accumulator += byte (8-bit wrap); after index 7 -> SUM.
REQ-019 SUM: byte equal to accumulator -> load roll={b1,b0}, pitch={b3,b2}, yaw={b5,b4} and pulse angle_valid on the cycle after the byte strobe; mismatch -> pulse frame_err, outputs unchanged; both -> HUNT.
REQ-020 Bytes 6-7 (version) SHALL be checksummed but not output.
REQ-021 roll/pitch/yaw SHALL update atomically, only from a complete frame; partial frames never alter outputs.
REQ-022 In TYPE/DATA/SUM, no byte strobe for 20*CLKS_PER_BIT cycles SHALL pulse frame_err and return to HUNT; counter restarts on every byte strobe.
REQ-023 angle_valid and frame_err SHALL never assert in the same cycle.
REQ-024 Back-to-back frames with no idle gap SHALL all be accepted.

Reset
REQ-025 PRESETn low SHALL immediately force roll=pitch=yaw=0, angle_valid=0, frame_err=0, UART idle, parser HUNT, counters 0.
REQ-026 Reset mid-byte or mid-frame SHALL discard all partial data; first frame after release is accepted only from its 0x55 header.

Configuration
REQ-027 With macro JY61P_CHECKSUM_EN defined, REQ-019 checksum compare SHALL apply; undefined, SUM byte SHALL be consumed without compare and frame always accepted (stop-bit and timeout errors still pulse frame_err).

Verification
REQ-028 Frame 55 53 00 10 00 F0 34 12 00 00 EE at 9600 baud -> one angle_valid pulse; roll=0x1000, pitch=0xF000, yaw=0x1234.
REQ-029 Same frame with SUM=0xEF, JY61P_CHECKSUM_EN defined -> frame_err pulse, outputs hold prior values; macro undefined -> angle_valid, outputs updated.
REQ-030 Bytes 55 51 ... (acceleration frame) then valid angle frame -> no frame_err for first, second accepted.
REQ-031 Valid frame with byte 4 stop bit forced low -> frame_err pulse, next valid frame accepted.
REQ-032 Send 55 53 00 10 then idle 25 bit-times -> frame_err at 20 bit-times after last strobe, parser in HUNT.
REQ-033 Assert PRESETn low during byte 7 of a frame -> outputs 0 at once; after release a full valid frame updates outputs exactly once.

Source files
------------

// File: rtl/jy61p_angle_rx_if.sv
// Sensor-side signal bundle for the JY61P angle receiver.
// The slave modport is the receiver and the master modport is the sensor/host side.
interface jy61p_angle_rx_if;
  logic        jy61p_uart_rx;
  logic [15:0] roll;
  logic [15:0] pitch;
  logic [15:0] yaw;
  logic        angle_valid;
  logic        frame_err;

  modport slave  (input  jy61p_uart_rx,
                  output roll, pitch, yaw, angle_valid, frame_err);
  modport master (output jy61p_uart_rx,
                  input  roll, pitch, yaw, angle_valid, frame_err);
endinterface

// File: rtl/jy61p_angle_rx.sv
// JY61P UART angle-frame receiver: 8N1 byte receiver feeding a 0x55/0x53 frame parser.
// Define JY61P_CHECKSUM_EN to reject frames whose trailing sum byte does not match.
module jy61p_angle_rx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input logic             PCLK,
  input logic             PRESETn,
  jy61p_angle_rx_if.slave bus
);
  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int TO   = 20 * CPB;
  localparam int CW   = $clog2(CPB + 1);
  localparam int TW   = $clog2(TO + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CPB - 1);
  localparam logic [TW-1:0] TO_M1   = TW'(TO - 1);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} u_state_t;
  typedef enum logic [1:0] {HUNT, TYPE, DATA, SUM} p_state_t;

  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= bus.jy61p_uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end

  // UART byte receiver
  u_state_t      ust_q, ust_n;
  logic [CW-1:0] ucnt_q, ucnt_n;
  logic [2:0]    bit_q, bit_n;
  logic [7:0]    shift_q, shift_n;
  logic          byte_stb, stop_err;

  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      ust_q   <= U_IDLE;
      ucnt_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      ust_q   <= ust_n;
      ucnt_q  <= ucnt_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
    end

  always_comb begin
    ust_n    = ust_q;
    ucnt_n   = ucnt_q;
    bit_n    = bit_q;
    shift_n  = shift_q;
    byte_stb = 1'b0;
    stop_err = 1'b0;
    case (ust_q)
      U_IDLE: begin
        ucnt_n = '0;
        if (rx_prev && !rx_sync) ust_n = U_START;
      end
      U_START:
        if (ucnt_q == HALF_M1) begin
          ucnt_n = '0;
          bit_n  = '0;
          ust_n  = rx_sync ? U_IDLE : U_DATA;
        end else ucnt_n = ucnt_q + CW'(1);
      U_DATA:
        if (ucnt_q == BIT_M1) begin
          ucnt_n  = '0;
          shift_n = {rx_sync, shift_q[7:1]};
          bit_n   = bit_q + 3'd1;
          if (bit_q == 3'd7) ust_n = U_STOP;
        end else ucnt_n = ucnt_q + CW'(1);
      U_STOP:
        if (ucnt_q == BIT_M1) begin
          ucnt_n   = '0;
          ust_n    = U_IDLE;
          byte_stb = rx_sync;
          stop_err = !rx_sync;
        end else ucnt_n = ucnt_q + CW'(1);
      default: ust_n = U_IDLE;
    endcase
  end

  // Frame parser; payload bytes are staged and only copied to outputs on a good SUM
  p_state_t          ps_q, ps_n;
  logic [7:0]        acc_q, acc_n;
  logic [2:0]        idx_q, idx_n;
  logic [5:0][7:0]   data_q, data_n;
  logic [TW-1:0]     tcnt_q, tcnt_n;
  logic [15:0]       roll_q, roll_n, pitch_q, pitch_n, yaw_q, yaw_n;
  logic              av_q, av_n, fe_q, fe_n;

  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      ps_q    <= HUNT;
      acc_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      tcnt_q  <= '0;
      roll_q  <= '0;
      pitch_q <= '0;
      yaw_q   <= '0;
      av_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      ps_q    <= ps_n;
      acc_q   <= acc_n;
      idx_q   <= idx_n;
      data_q  <= data_n;
      tcnt_q  <= tcnt_n;
      roll_q  <= roll_n;
      pitch_q <= pitch_n;
      yaw_q   <= yaw_n;
      av_q    <= av_n;
      fe_q    <= fe_n;
    end

  always_comb begin
    ps_n    = ps_q;
    acc_n   = acc_q;
    idx_n   = idx_q;
    data_n  = data_q;
    tcnt_n  = tcnt_q;
    roll_n  = roll_q;
    pitch_n = pitch_q;
    yaw_n   = yaw_q;
    av_n    = 1'b0;
    fe_n    = 1'b0;
    if (stop_err) begin
      fe_n   = (ps_q != HUNT);
      ps_n   = HUNT;
      tcnt_n = '0;
    end else if (byte_stb) begin
      tcnt_n = '0;
      case (ps_q)
        HUNT:
          if (shift_q == 8'h55) begin
            ps_n  = TYPE;
            acc_n = 8'h55;
          end
        TYPE:
          if (shift_q == 8'h53) begin
            ps_n  = DATA;
            acc_n = acc_q + 8'h53;
            idx_n = '0;
          end else if (shift_q == 8'h55) acc_n = 8'h55;
          else ps_n = HUNT;
        DATA: begin
          acc_n = acc_q + shift_q;
          if (idx_q < 3'd6) data_n[idx_q] = shift_q;
          idx_n = idx_q + 3'd1;
          if (idx_q == 3'd7) ps_n = SUM;
        end
        SUM: begin
          ps_n = HUNT;
`ifdef JY61P_CHECKSUM_EN
          if (shift_q == acc_q) begin
            roll_n  = {data_q[1], data_q[0]};
            pitch_n = {data_q[3], data_q[2]};
            yaw_n   = {data_q[5], data_q[4]};
            av_n    = 1'b1;
          end else fe_n = 1'b1;
`else
          roll_n  = {data_q[1], data_q[0]};
          pitch_n = {data_q[3], data_q[2]};
          yaw_n   = {data_q[5], data_q[4]};
          av_n    = 1'b1;
`endif
        end
        default: ps_n = HUNT;
      endcase
    end else if (ps_q != HUNT) begin
      if (tcnt_q == TO_M1) begin
        fe_n   = 1'b1;
        ps_n   = HUNT;
        tcnt_n = '0;
      end else tcnt_n = tcnt_q + TW'(1);
    end
  end

  assign bus.roll        = roll_q;
  assign bus.pitch       = pitch_q;
  assign bus.yaw         = yaw_q;
  assign bus.angle_valid = av_q;
  assign bus.frame_err   = fe_q;
endmodule

// File: tb/tb_jy61p_angle_rx.sv
// Directed + randomized bench for jy61p_angle_rx with a frame-level reference model.
module tb_jy61p_angle_rx;
  localparam int CLK_FREQ = 153600;
  localparam int BAUD     = 9600;
  localparam int CPB      = CLK_FREQ / BAUD;
`ifdef JY61P_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  jy61p_angle_rx_if bus ();

  jy61p_angle_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus));

  always #5 PCLK = ~PCLK;

  int ncmp = 0, nerr = 0;
  int nav = 0, nfe = 0, nboth = 0, cyc = 0;
  always @(posedge PCLK) begin
    cyc <= cyc + 1;
    if (bus.angle_valid) nav <= nav + 1;
    if (bus.frame_err) nfe <= nfe + 1;
    if (bus.angle_valid && bus.frame_err) nboth <= nboth + 1;
  end

  logic [7:0]  frm [0:10];
  logic [15:0] exp_roll = '0, exp_pitch = '0, exp_yaw = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clk(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    bus.jy61p_uart_rx = 1'b0;
    clk(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.jy61p_uart_rx = b[i];
      clk(CPB);
    end
    bus.jy61p_uart_rx = stop_ok;
    clk(CPB);
    bus.jy61p_uart_rx = 1'b1;
  endtask

  task automatic send_frame(input int bad_stop);
    for (int i = 0; i < 11; i++) send_byte(frm[i], i != bad_stop);
  endtask

  function automatic logic [7:0] csum();
    logic [7:0] s = '0;
    for (int i = 0; i < 10; i++) s = s + frm[i];
    return s;
  endfunction

  // Angle frame: header, 8 payload bytes, trailing modulo-256 sum of the first ten bytes
  task automatic build(input logic [7:0] d [0:7]);
    frm[0] = 8'h55;
    frm[1] = 8'h53;
    for (int i = 0; i < 8; i++) frm[i+2] = d[i];
    frm[10] = csum();
  endtask

  task automatic build_rand();
    logic [7:0] d [0:7];
    for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
    build(d);
  endtask

  task automatic build_ref();
    logic [7:0] d [0:7];
    d = '{8'h00, 8'h10, 8'h00, 8'hF0, 8'h34, 8'h12, 8'h00, 8'h00};
    build(d);
  endtask

  function automatic bit model(input int bad_stop);
    bit acc;
    acc = (bad_stop < 0) && (!CK || csum() == frm[10]);
    if (acc) begin
      exp_roll  = {frm[3], frm[2]};
      exp_pitch = {frm[5], frm[4]};
      exp_yaw   = {frm[7], frm[6]};
    end
    return acc;
  endfunction

  task automatic check_out(input string tag);
    chk({tag, "_roll"},  bus.roll,  exp_roll);
    chk({tag, "_pitch"}, bus.pitch, exp_pitch);
    chk({tag, "_yaw"},   bus.yaw,   exp_yaw);
  endtask

  task automatic run_frame(input int bad_stop, input string tag);
    int nav0, nfe0;
    bit acc;
    nav0 = nav;
    nfe0 = nfe;
    acc  = model(bad_stop);
    send_frame(bad_stop);
    clk(2);
    chk({tag, "_av"}, nav - nav0, acc ? 1 : 0);
    chk({tag, "_fe"}, nfe - nfe0, acc ? 0 : 1);
    check_out(tag);
  endtask

  initial begin
    int nav0, nfe0, t0, dt;
    bit acc;
    bus.jy61p_uart_rx = 1'b1;
    PRESETn = 1'b0;
    clk(3);
    check_out("rst");
    chk("rst_av", bus.angle_valid, 0);
    chk("rst_fe", bus.frame_err, 0);
    PRESETn = 1'b1;
    clk(5);

    // Reference frame with hand-computed results
    build_ref();
    run_frame(-1, "ref");
    chk("ref_roll_k",  bus.roll,  32'h1000);
    chk("ref_pitch_k", bus.pitch, 32'hF000);
    chk("ref_yaw_k",   bus.yaw,   32'h1234);

    // Same frame with a wrong sum byte
    build_ref();
    frm[10] = 8'hEF;
    run_frame(-1, "badsum");

    // Acceleration frame is ignored silently, following angle frame accepted
    nfe0 = nfe;
    nav0 = nav;
    send_byte(8'h55, 1'b1);
    send_byte(8'h51, 1'b1);
    for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1);
    clk(2);
    chk("acc_fe", nfe - nfe0, 0);
    chk("acc_av", nav - nav0, 0);
    build_rand();
    run_frame(-1, "after_acc");

    // Stop bit low on byte 4, then a quiet gap and a good frame
    build_ref();
    frm[2] = 8'h77;
    frm[10] = csum();
    run_frame(4, "badstop");
    clk(25 * CPB);
    build_rand();
    run_frame(-1, "after_stop");

    // Inter-byte timeout
    nfe0 = nfe;
    nav0 = nav;
    send_byte(8'h55, 1'b1);
    send_byte(8'h53, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b1);
    t0 = cyc;
    for (int i = 0; i < 30 * CPB && nfe == nfe0; i++) clk(1);
    dt = cyc - t0;
    chk("to_fe", nfe - nfe0, 1);
    chk("to_window", (dt >= 19 * CPB) && (dt <= 20 * CPB), 1);
    clk(5 * CPB);
    chk("to_fe_once", nfe - nfe0, 1);
    chk("to_av", nav - nav0, 0);
    check_out("to");
    build_rand();
    run_frame(-1, "after_to");

    // Two frames with no idle gap
    nav0 = nav;
    nfe0 = nfe;
    build_rand();
    acc = model(-1);
    send_frame(-1);
    build_rand();
    acc = model(-1);
    send_frame(-1);
    clk(2);
    chk("b2b_av", nav - nav0, 2);
    chk("b2b_fe", nfe - nfe0, 0);
    check_out("b2b");

    // Randomized frames, some with a corrupted sum
    for (int k = 0; k < 6; k++) begin
      build_rand();
      if ($urandom_range(2) == 0) frm[10] = frm[10] ^ 8'($urandom_range(255, 1));
      run_frame(-1, $sformatf("rnd%0d", k));
    end

    // Reset in the middle of byte 7
    build_rand();
    frm[2] = 8'hA5;
    frm[10] = csum();
    run_frame(-1, "pre_rst");
    build_rand();
    for (int i = 0; i < 7; i++) send_byte(frm[i], 1'b1);
    bus.jy61p_uart_rx = 1'b0;
    clk(CPB + 3);
    #2 PRESETn = 1'b0;
    #1;
    exp_roll  = '0;
    exp_pitch = '0;
    exp_yaw   = '0;
    check_out("midrst");
    clk(3);
    bus.jy61p_uart_rx = 1'b1;
    PRESETn = 1'b1;
    clk(2 * CPB);
    build_rand();
    run_frame(-1, "post_rst");

    chk("never_both", nboth, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
